bcd_updown_counter: RTL and testbench

- Parametrised DIGITS-wide packed-BCD up/down counter.
- Next generation of the free-running binary display counter: counts natively in BCD, so the 74HC595 display path can take digits directly.
- Adds direction, enable, synchronous clear/load, wrap or saturate mode, carry/borrow pulses and a sticky overflow flag.
- Runs in the divided clock domain (clk2) and feeds the display's data bus.

---
 rtl/bcd_updown_counter.sv | 111 +++++++++++
 tb/tb_bcd_updown_counter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// Packed-BCD up/down counter with clear/load, wrap or saturate limits,
// registered carry/borrow pulses and a sticky overflow flag.
module bcd_updown_counter #(
    parameter int                   DIGITS = 8,
    parameter bit                   WRAP   = 1'b1,
    parameter logic [4*DIGITS-1:0]  INIT   = '0
) (
    input  logic                  clk2,
    input  logic                  rst3,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  carry,
    output logic                  borrow,
    output logic                  at_max,
    output logic                  at_zero,
    output logic                  ovf
);

    localparam int              W    = 4 * DIGITS;
    localparam logic [W-1:0]    ALL9 = {DIGITS{4'h9}};

    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic [W-1:0] clamp_val;
    logic         inc_c;
    logic         dec_b;
    logic [3:0]   digit;
    logic [3:0]   ld_digit;

    assign at_max  = (bcd == ALL9);
    assign at_zero = (bcd == '0);

    // Per-digit ripple for both directions plus the clamped load value;
    // the whole chain settles within one clk2 cycle.
    always_comb begin
        inc_val   = '0;
        dec_val   = '0;
        clamp_val = '0;
        inc_c     = 1'b1;
        dec_b     = 1'b1;
        digit     = '0;
        ld_digit  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = bcd[4*i +: 4];
            if (!inc_c) begin
                inc_val[4*i +: 4] = digit;
            end else if (digit >= 4'd9) begin
                inc_val[4*i +: 4] = 4'd0;
            end else begin
                inc_val[4*i +: 4] = digit + 4'd1;
                inc_c             = 1'b0;
            end
            if (!dec_b) begin
                dec_val[4*i +: 4] = digit;
            end else if (digit == 4'd0) begin
                dec_val[4*i +: 4] = 4'd9;
            end else begin
                dec_val[4*i +: 4] = digit - 4'd1;
                dec_b             = 1'b0;
            end
            ld_digit = load_val[4*i +: 4];
            clamp_val[4*i +: 4] = (ld_digit > 4'd9) ? 4'd9 : ld_digit;
        end
    end

    // Priority is clr > load > en; carry/borrow default low so they pulse once.
    always_ff @(posedge clk2 or negedge rst3) begin
        if (!rst3) begin
            bcd    <= INIT;
            carry  <= 1'b0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            carry  <= 1'b0;
            borrow <= 1'b0;
            if (clr) begin
                bcd <= INIT;
                ovf <= 1'b0;
            end else if (load) begin
                bcd <= clamp_val;
            end else if (en) begin
                if (up) begin
                    if (at_max) begin
                        ovf <= 1'b1;
                        if (WRAP) begin
                            bcd   <= '0;
                            carry <= 1'b1;
                        end
                    end else begin
                        bcd <= inc_val;
                    end
                end else begin
                    if (at_zero) begin
                        ovf <= 1'b1;
                        if (WRAP) begin
                            bcd    <= ALL9;
                            borrow <= 1'b1;
                        end
                    end else begin
                        bcd <= dec_val;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench: a wrapping and a saturating 4-digit counter share one
// stimulus stream; each scenario task checks its own expected values.
module tb_bcd_updown_counter;

    logic        clk2 = 1'b0;
    logic        rst3;
    logic        en, up, clr, load;
    logic [15:0] load_val;

    logic [15:0] w_bcd, s_bcd;
    logic        w_carry, w_borrow, w_max, w_zero, w_ovf;
    logic        s_carry, s_borrow, s_max, s_zero, s_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk2 = ~clk2;

    bcd_updown_counter #(.DIGITS(4), .WRAP(1'b1), .INIT(16'h0000)) u_wrap (
        .clk2(clk2), .rst3(rst3), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .bcd(w_bcd), .carry(w_carry), .borrow(w_borrow),
        .at_max(w_max), .at_zero(w_zero), .ovf(w_ovf)
    );

    bcd_updown_counter #(.DIGITS(4), .WRAP(1'b0), .INIT(16'h0000)) u_sat (
        .clk2(clk2), .rst3(rst3), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .bcd(s_bcd), .carry(s_carry), .borrow(s_borrow),
        .at_max(s_max), .at_zero(s_zero), .ovf(s_ovf)
    );

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        clr      = 1'b0;
        load     = 1'b1;
        load_val = v;
        tick();
        load     = 1'b0;
    endtask

    task automatic test_reset();
        rst3 = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
        tick();
        tick();
        n_checks++;
        if (w_bcd !== 16'h0000 || w_carry !== 1'b0 || w_borrow !== 1'b0 || w_ovf !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: bcd=%h c=%b b=%b ovf=%b, expected 0000 0 0 0",
                     w_bcd, w_carry, w_borrow, w_ovf);
        end
        n_checks++;
        if (w_zero !== 1'b1 || w_max !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: at_zero=%b at_max=%b, expected 1 0", w_zero, w_max);
        end
        rst3 = 1'b1;
    endtask

    task automatic test_count_up();
        logic [15:0] exp;
        en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp = 16'((i / 10) * 16 + (i % 10));
            n_checks++;
            if (w_bcd !== exp || w_carry !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL count_up[%0d]: bcd=%h carry=%b, expected %h 0", i, w_bcd, w_carry, exp);
            end
            for (int d = 0; d < 4; d++) begin
                n_checks++;
                if (w_bcd[4*d +: 4] > 4'd9) begin
                    n_fail++;
                    $display("[TB] FAIL nibble_range[%0d]: digit %0d = %h, expected <= 9", i, d, w_bcd[4*d +: 4]);
                end
            end
        end
    endtask

    task automatic test_wrap_up();
        do_load(16'h9998);
        en = 1'b1; up = 1'b1;
        n_checks++;
        if (w_bcd !== 16'h9998) begin
            n_fail++;
            $display("[TB] FAIL load_9998: bcd=%h, expected 9998", w_bcd);
        end
        tick();
        n_checks++;
        if (w_bcd !== 16'h9999 || w_max !== 1'b1 || w_carry !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL up_to_max: bcd=%h at_max=%b carry=%b, expected 9999 1 0", w_bcd, w_max, w_carry);
        end
        tick();
        n_checks++;
        if (w_bcd !== 16'h0000 || w_carry !== 1'b1 || w_ovf !== 1'b1 || w_borrow !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL up_wrap: bcd=%h carry=%b ovf=%b borrow=%b, expected 0000 1 1 0",
                     w_bcd, w_carry, w_ovf, w_borrow);
        end
        n_checks++;
        if (s_bcd !== 16'h9999 || s_carry !== 1'b0 || s_ovf !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL up_saturate: bcd=%h carry=%b ovf=%b, expected 9999 0 1", s_bcd, s_carry, s_ovf);
        end
        tick();
        n_checks++;
        if (w_bcd !== 16'h0001 || w_carry !== 1'b0 || w_ovf !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL after_wrap: bcd=%h carry=%b ovf=%b, expected 0001 0 1", w_bcd, w_carry, w_ovf);
        end
    endtask

    task automatic test_saturate_down();
        logic exp_ovf;
        // Clear first so the saturating counter's sticky flag starts low.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        do_load(16'h0001);
        en = 1'b1; up = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_ovf = (i >= 2);
            n_checks++;
            if (s_bcd !== 16'h0000 || s_borrow !== 1'b0 || s_zero !== 1'b1 || s_ovf !== exp_ovf) begin
                n_fail++;
                $display("[TB] FAIL sat_down[%0d]: bcd=%h borrow=%b at_zero=%b ovf=%b, expected 0000 0 1 %b",
                         i, s_bcd, s_borrow, s_zero, s_ovf, exp_ovf);
            end
        end
    endtask

    task automatic test_priority();
        clr = 1'b1; load = 1'b1; load_val = 16'h5555; en = 1'b1; up = 1'b1;
        tick();
        n_checks++;
        if (w_bcd !== 16'h0000 || w_ovf !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clr_priority: bcd=%h ovf=%b, expected 0000 0", w_bcd, w_ovf);
        end
        clr = 1'b0; load = 1'b1; load_val = 16'hA3F1;
        tick();
        load = 1'b0; en = 1'b0;
        n_checks++;
        if (w_bcd !== 16'h9391 || w_ovf !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL load_clamp: bcd=%h ovf=%b, expected 9391 0", w_bcd, w_ovf);
        end
        tick();
        n_checks++;
        if (w_bcd !== 16'h9391) begin
            n_fail++;
            $display("[TB] FAIL hold_disabled: bcd=%h, expected 9391", w_bcd);
        end
    endtask

    task automatic test_back_to_back();
        do_load(16'h0099);
        en = 1'b1; up = 1'b1;
        tick();
        n_checks++;
        if (w_bcd !== 16'h0100) begin
            n_fail++;
            $display("[TB] FAIL ripple_0100: bcd=%h, expected 0100", w_bcd);
        end
        tick();
        up = 1'b0;
        n_checks++;
        if (w_bcd !== 16'h0101) begin
            n_fail++;
            $display("[TB] FAIL up_0101: bcd=%h, expected 0101", w_bcd);
        end
        tick();
        n_checks++;
        if (w_bcd !== 16'h0100) begin
            n_fail++;
            $display("[TB] FAIL dir_change: bcd=%h, expected 0100", w_bcd);
        end
        tick();
        n_checks++;
        if (w_bcd !== 16'h0099) begin
            n_fail++;
            $display("[TB] FAIL borrow_ripple: bcd=%h, expected 0099", w_bcd);
        end
        do_load(16'h0000);
        tick();
        n_checks++;
        if (w_bcd !== 16'h9999 || w_borrow !== 1'b1 || w_carry !== 1'b0 || w_ovf !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL down_wrap: bcd=%h borrow=%b carry=%b ovf=%b, expected 9999 1 0 1",
                     w_bcd, w_borrow, w_carry, w_ovf);
        end
        tick();
        n_checks++;
        if (w_bcd !== 16'h9998 || w_borrow !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL after_borrow: bcd=%h borrow=%b, expected 9998 0", w_bcd, w_borrow);
        end
    endtask

    task automatic test_async_reset();
        en = 1'b0;
        do_load(16'h0420);
        n_checks++;
        if (w_bcd !== 16'h0420) begin
            n_fail++;
            $display("[TB] FAIL load_0420: bcd=%h, expected 0420", w_bcd);
        end
        #2;
        rst3 = 1'b0;
        #1;
        n_checks++;
        if (w_bcd !== 16'h0000 || w_ovf !== 1'b0 || w_carry !== 1'b0 || w_borrow !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: bcd=%h ovf=%b c=%b b=%b, expected 0000 0 0 0",
                     w_bcd, w_ovf, w_carry, w_borrow);
        end
        #3;
        rst3 = 1'b1;
        en = 1'b1; up = 1'b1;
        tick();
        n_checks++;
        if (w_bcd !== 16'h0001) begin
            n_fail++;
            $display("[TB] FAIL resume_after_reset: bcd=%h, expected 0001", w_bcd);
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap_up();
        test_saturate_down();
        test_priority();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
